// File: rtl/keypad_event_scanner.sv
// 4x4 keypad scanner: row sequencer, sweep-level debounce, press events and control bus.
// Define KEY_REPEAT_EN to enable auto-repeat of a single held key.
module keypad_event_scanner #(
  parameter int SCAN_DIV     = 250,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  keyPad_col,
  output logic [3:0]  keyPad_row,
  output logic [15:0] key_map,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [3:0]  control
);

  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_t;

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);

  row_t          state, state_nxt;
  logic [SW-1:0] slot_cnt;
  logic          slot_last, sweep_end, committed, commit, rpt, evt;
  logic [15:0]   raw, prev, old_map, newly, code_src;
  logic [DW-1:0] stable, stable_nxt;
  logic [3:0]    low_idx;

  assign slot_last = (slot_cnt == SW'(SCAN_DIV - 1));

  always_comb begin
    state_nxt  = state;
    keyPad_row = 4'b1111;
    case (state)
      ROW0: begin keyPad_row = 4'b1110; if (slot_last) state_nxt = ROW1; end
      ROW1: begin keyPad_row = 4'b1101; if (slot_last) state_nxt = ROW2; end
      ROW2: begin keyPad_row = 4'b1011; if (slot_last) state_nxt = ROW3; end
      ROW3: begin keyPad_row = 4'b0111; if (slot_last) state_nxt = ROW0; end
      default: state_nxt = ROW0;
    endcase
  end

  // Columns sample at the end of each slot, after SCAN_DIV-1 cycles of settling.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ROW0;
      slot_cnt  <= '0;
      raw       <= '0;
      sweep_end <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot_cnt  <= slot_last ? '0 : slot_cnt + 1'b1;
      sweep_end <= slot_last && (state == ROW3);
      if (slot_last) raw[{state, 2'b00} +: 4] <= ~keyPad_col;
    end
  end

  always_comb begin
    stable_nxt = '0;
    if (raw == prev)
      stable_nxt = (stable == DW'(DEBOUNCE_CNT)) ? stable : stable + 1'b1;
    commit = sweep_end && (stable_nxt == DW'(DEBOUNCE_CNT)) && (raw != key_map);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev      <= '0;
      stable    <= '0;
      key_map   <= '0;
      old_map   <= '0;
      committed <= 1'b0;
    end else begin
      committed <= commit;
      if (sweep_end) begin
        stable <= stable_nxt;
        prev   <= raw;
      end
      if (commit) begin
        old_map <= key_map;
        key_map <= raw;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = $clog2(HMAX + 1);

  logic [HW-1:0] hold, hold_tgt;
  logic          repeating, single;

  assign single   = (key_map != '0) && ((key_map & (key_map - 16'd1)) == '0);
  assign hold_tgt = repeating ? HW'(REPEAT_RATE) : HW'(REPEAT_DELAY);

  // Counts sweeps since the last commit; first target is the delay, then the rate.
  always_ff @(posedge clock) begin
    if (reset || commit) begin
      hold      <= '0;
      repeating <= 1'b0;
      rpt       <= 1'b0;
    end else begin
      rpt <= 1'b0;
      if (sweep_end && single) begin
        if (hold + 1'b1 == hold_tgt) begin
          hold      <= '0;
          repeating <= 1'b1;
          rpt       <= 1'b1;
        end else begin
          hold <= hold + 1'b1;
        end
      end
    end
  end
`else
  assign rpt = 1'b0;
`endif

  assign newly    = key_map & ~old_map;
  assign code_src = committed ? newly : key_map;
  assign evt      = (committed && (newly != '0)) || rpt;

  always_comb begin
    low_idx = '0;
    for (int i = 15; i >= 0; i--)
      if (code_src[i]) low_idx = 4'(i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= evt;
      if (evt) key_code <= low_idx;
    end
  end

  assign control = {key_map[0], key_map[5], key_map[6], key_map[4]};

endmodule
